// File: rtl/pipeline_ctrl_pkg.sv
// +---------------------------------------------------------------------------+
// | Package     : pipe_pkg                                                    |
// | Description : Shared FSM state encodings and register constants for the   |
// |               pipeline controller and its hazard detector.                |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
`default_nettype none

package pipe_pkg;

  // Encodings presented on state_o
  localparam logic [1:0] ST_IDLE_ENC     = 2'd0;
  localparam logic [1:0] ST_RUN_ENC      = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT_ENC = 2'd2;
  localparam logic [1:0] ST_ERROR_ENC    = 2'd3;

  // Controller FSM states
  typedef enum logic [1:0] {
    S_IDLE     = ST_IDLE_ENC,
    S_RUN      = ST_RUN_ENC,
    S_MEM_WAIT = ST_MEM_WAIT_ENC,
    S_ERROR    = ST_ERROR_ENC
  } state_e;

  // Register $zero never carries a real dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
// +---------------------------------------------------------------------------+
// | Module      : hazard_detect                                               |
// | Description : Combinational load-use hazard compare between the load in   |
// |               EX and the source registers of the instruction in ID.       |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
`default_nettype none

module hazard_detect
  import pipe_pkg::*;
(
  input  logic       i_ex_memread,
  input  logic [4:0] i_ex_rt,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  output logic       o_load_use
);

  logic w_rt_nonzero;
  logic w_src_match;

  assign w_rt_nonzero = (i_ex_rt != REG_ZERO);
  assign w_src_match  = (i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt);
  assign o_load_use   = i_ex_memread & w_rt_nonzero & w_src_match;

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// +---------------------------------------------------------------------------+
// | Module      : pipeline_ctrl                                               |
// | Description : 5-stage pipeline controller: load-use stall, branch/jump    |
// |               flush, data-memory wait with timeout, stall/flush counters. |
// |               Macro PIPE_PERF_CNT_EN enables the performance counters;    |
// |               without it the counter outputs are tied to zero.            |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
`default_nettype none

module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             start_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             id_branch_taken_i,
  input  logic             id_jump_i,
  input  logic             mem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             exmem_hold_o,
  output logic             dmem_req_o,
  output logic             is_stall_o,
  output logic             is_flush_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [1:0]       state_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_err;

  logic w_load_use;
  logic w_ctrl_xfer;
  logic w_mem_stall;
  logic w_timeout;

  logic w_pc_write;
  logic w_ifid_write;
  logic w_ifid_flush;
  logic w_idex_bubble;
  logic w_exmem_hold;
  logic w_dmem_req;
  logic w_is_stall;
  logic w_is_flush;

  hazard_detect u_hazard_detect (
    .i_ex_memread (ex_memread_i),
    .i_ex_rt      (ex_rt_i),
    .i_id_rs      (id_rs_i),
    .i_id_rt      (id_rt_i),
    .o_load_use   (w_load_use)
  );

  assign w_ctrl_xfer = id_branch_taken_i | id_jump_i;
  assign w_mem_stall = mem_req_i & ~dmem_ack_i;
  // The cycle whose increment would reach MEM_TIMEOUT is the last one allowed
  assign w_timeout   = ((r_wait_cnt + WAIT_W'(1)) == WAIT_W'(MEM_TIMEOUT));

  // State register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; ack wins over timeout in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     w_state_nxt = S_RUN;
      S_RUN:      if (w_mem_stall) w_state_nxt = S_MEM_WAIT;
      S_MEM_WAIT: begin
        if (dmem_ack_i) begin
          w_state_nxt = S_RUN;
        end else if (w_timeout) begin
          w_state_nxt = S_ERROR;
        end
      end
      S_ERROR:    w_state_nxt = S_ERROR;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Pipeline controls: memory freeze > load-use stall > control-transfer flush
  always_comb begin
    w_pc_write    = 1'b0;
    w_ifid_write  = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_exmem_hold  = 1'b0;
    w_dmem_req    = 1'b0;
    w_is_stall    = 1'b0;
    w_is_flush    = 1'b0;
    case (r_state)
      S_RUN: begin
        w_dmem_req = mem_req_i;
        if (w_mem_stall) begin
          w_exmem_hold = 1'b1;
          w_is_stall   = 1'b1;
        end else if (w_load_use) begin
          w_idex_bubble = 1'b1;
          w_is_stall    = 1'b1;
        end else if (w_ctrl_xfer) begin
          w_pc_write   = 1'b1;
          w_ifid_write = 1'b1;
          w_ifid_flush = 1'b1;
          w_is_flush   = 1'b1;
        end else begin
          w_pc_write   = 1'b1;
          w_ifid_write = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        w_dmem_req   = 1'b1;
        w_exmem_hold = 1'b1;
        w_is_stall   = 1'b1;
      end
      S_ERROR: begin
        w_exmem_hold = 1'b1;
        w_is_stall   = 1'b1;
      end
      default: begin
        w_pc_write = 1'b0;
      end
    endcase
  end

  // Memory wait counter runs only while parked in MEM_WAIT
  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_MEM_WAIT) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Sticky error flag, set together with the entry into ERROR
  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      r_err <= 1'b0;
    end else if (w_state_nxt == S_ERROR) begin
      r_err <= 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating stall/flush event counters
  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_is_stall && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_is_flush && !(&r_flush_cnt)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

  assign pc_write_o    = w_pc_write;
  assign ifid_write_o  = w_ifid_write;
  assign ifid_flush_o  = w_ifid_flush;
  assign idex_bubble_o = w_idex_bubble;
  assign exmem_hold_o  = w_exmem_hold;
  assign dmem_req_o    = w_dmem_req;
  assign is_stall_o    = w_is_stall;
  assign is_flush_o    = w_is_flush;
  assign err_o         = r_err;
  assign state_o       = r_state;

endmodule

`default_nettype wire

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of stall/flush performance counters.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16, maximum cycles waiting for dmem_ack_i before error.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port start_i  input  1  synchronous active-low reset; low = reset.
REQ-005 SHALL have port id_rs_i / id_rt_i  input  5 each  source registers of instruction in ID.
REQ-006 SHALL have port ex_memread_i  input  1  instruction in EX is a load.
REQ-007 SHALL have port ex_rt_i  input  5  destination register of load in EX.
REQ-008 SHALL have port id_branch_taken_i / id_jump_i  input  1 each  control transfer resolved in ID.
REQ-009 SHALL have port mem_req_i  input  1  MEM stage holds a load/store.
REQ-010 SHALL have port dmem_ack_i  input  1  data memory completed access.
REQ-011 SHALL have ports pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, exmem_hold_o, dmem_req_o  output  1 each  pipeline controls.
REQ-012 SHALL have ports is_stall_o, is_flush_o, err_o  output  1 each  status.
REQ-013 SHALL have ports stall_cnt_o, flush_cnt_o  output  CNT_W each; state_o  output  2.

Function
REQ-014 FSM states SHALL be IDLE=0, RUN=1, MEM_WAIT=2, ERROR=3, shown on state_o.
REQ-015 IDLE: all pipeline writes blocked (pc_write_o=0, ifid_write_o=0); next cycle -> RUN unconditionally.
REQ-016 RUN, no hazard: pc_write_o=1, ifid_write_o=1, all other controls 0.
REQ-017 Load-use hazard = ex_memread_i & ex_rt_i!=0 & (ex_rt_i==id_rs_i | ex_rt_i==id_rt_i); in RUN it SHALL give pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, is_stall_o=1.
REQ-018 In RUN, id_branch_taken_i|id_jump_i without load-use hazard SHALL give ifid_flush_o=1, is_flush_o=1, pc_write_o=1.
REQ-019 Load-use and branch same cycle: stall wins, flush suppressed that cycle.
REQ-020 dmem_req_o SHALL equal mem_req_i in RUN and be held 1 in MEM_WAIT; 0 in IDLE/ERROR.
REQ-021 RUN with mem_req_i=1, dmem_ack_i=0 -> MEM_WAIT; that cycle and every MEM_WAIT cycle SHALL freeze pipeline: pc_write_o=0, ifid_write_o=0, exmem_hold_o=1, idex_bubble_o=0, ifid_flush_o=0, is_stall_o=1.
REQ-022 mem_req_i with dmem_ack_i=1 same cycle SHALL not stall (zero-wait access).
REQ-023 MEM_WAIT: wait counter increments each cycle; dmem_ack_i=1 -> RUN next cycle (freeze still asserted in ack cycle); counter reaching MEM_TIMEOUT without ack -> ERROR.
REQ-024 Memory wait SHALL take priority over load-use and flush.
REQ-025 ERROR: all controls as MEM_WAIT except dmem_req_o=0; err_o=1 sticky until reset.
REQ-026 stall_cnt_o increments once per cycle with is_stall_o=1; flush_cnt_o once per cycle with is_flush_o=1; both saturate at all-ones.

Reset
REQ-027 start_i=0 at rising edge SHALL force state IDLE, wait counter 0, err_o=0, counters 0; mid-operation reset abandons MEM_WAIT/ERROR immediately.
REQ-028 During reset all outputs SHALL be 0 except state_o=IDLE.

Configuration
REQ-029 Macro PIPE_PERF_CNT_EN defined: stall/flush counters implemented per REQ-026.
REQ-030 Macro undefined: no counter registers; stall_cnt_o and flush_cnt_o tied to 0; all else unchanged.

Structure
REQ-031 Shared package pipe_pkg SHALL hold FSM state enumeration, state_o encodings, REG_ZERO=5'd0.
REQ-032 One sub-module hazard_detect (combinational load-use compare) is natural; FSM, counters in pipeline_ctrl.

Verification
REQ-033 Reset release, no hazards: cycle 0 state_o=0, cycle 1 state_o=1, pc_write_o=1, counters 0.
REQ-034 ex_memread_i=1, ex_rt_i=8, id_rs_i=8 for 1 cycle -> idex_bubble_o=1, pc_write_o=0, stall_cnt_o=1; ex_rt_i=0 same inputs -> no stall.
REQ-035 id_branch_taken_i=1 one cycle -> ifid_flush_o=1, flush_cnt_o=1; with simultaneous load-use -> ifid_flush_o=0, stall_cnt_o=1, flush_cnt_o=0.
REQ-036 mem_req_i=1, dmem_ack_i asserted after 3 cycles -> 4 freeze cycles, exmem_hold_o=1 throughout, state_o=2 then 1, stall_cnt_o=4.
REQ-037 mem_req_i=1, no ack -> ERROR after MEM_TIMEOUT=16 cycles, err_o=1 held; start_i=0 one cycle -> err_o=0, state_o=0.
REQ-038 CNT_W=4, 20 stall cycles -> stall_cnt_o=15 saturated; build without PIPE_PERF_CNT_EN -> counters read 0.
